// File: rtl/instr_encode_pkg.sv
// Instruction format enumeration, immediate range limits and opcode-to-format mapping.
`include "instr_encode_defines.sv"

package instr_encode_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam int IMM_I_BITS = 12;
  localparam int IMM_S_BITS = 12;
  localparam int IMM_B_BITS = 13;
  localparam int IMM_U_BITS = 32;
  localparam int IMM_J_BITS = 21;
  localparam int SHAMT_MAX  = 63;
  localparam int SHAMTW_MAX = 31;

  function automatic fmt_e fmt_of(input logic [6:0] op);
    case (op)
      `OPC_JALR, `OPC_LOAD, `OPC_OP_IMM, `OPC_OP_IMM_W: fmt_of = FMT_I;
      `OPC_LUI, `OPC_AUIPC:                             fmt_of = FMT_U;
      `OPC_JAL:                                         fmt_of = FMT_J;
      `OPC_BRANCH:                                      fmt_of = FMT_B;
      `OPC_STORE:                                       fmt_of = FMT_S;
      default:                                          fmt_of = FMT_R;
    endcase
  endfunction

endpackage

// File: rtl/instr_encode_defines.sv
// Shared RV64 major-opcode constants used by the encoder, decode-side checkers and benches.
`ifndef INSTR_ENCODE_DEFINES_SV
`define INSTR_ENCODE_DEFINES_SV

`define OPC_LUI      7'b0110111
`define OPC_AUIPC    7'b0010111
`define OPC_JAL      7'b1101111
`define OPC_JALR     7'b1100111
`define OPC_BRANCH   7'b1100011
`define OPC_LOAD     7'b0000011
`define OPC_STORE    7'b0100011
`define OPC_OP_IMM   7'b0010011
`define OPC_OP_IMM_W 7'b0011011
`define OPC_OP       7'b0110011
`define OPC_OP_W     7'b0111011

`endif

// File: rtl/instr_encode_imm_pack.sv
// Combinational field placement and immediate range check for one decoded instruction.
`include "instr_encode_defines.sv"

module instr_encode_imm_pack
  import instr_encode_pkg::*;
#(
  parameter int W = 64
) (
  input  logic [6:0]   opcode,
  input  logic [2:0]   func3,
  input  logic         func7,
  input  logic [4:0]   rs1,
  input  logic [4:0]   rs2,
  input  logic [4:0]   rd,
  input  logic [W-1:0] imme,
  output logic [31:0]  word,
  output logic         err
);

  // True when v sign-extends from its low 'bits' bits.
  function automatic logic fits(input logic [W-1:0] v, input int bits);
    logic [W-1:0] hi;
    hi = $signed(v) >>> (bits - 1);
    return (hi == '0) || (hi == '1);
  endfunction

  fmt_e fmt_s;
  logic is_shift_s;
  logic is_w_s;

  // Select layout from the format and flag immediates the layout truncates.
  always_comb begin
    fmt_s      = fmt_of(opcode);
    is_w_s     = (opcode == `OPC_OP_IMM_W);
    is_shift_s = ((opcode == `OPC_OP_IMM) || is_w_s) && ((func3 == 3'b001) || (func3 == 3'b101));
    word       = 32'd0;
    err        = 1'b0;
    case (fmt_s)
      FMT_I: begin
        if (is_shift_s) begin
          word = {1'b0, func7, 4'b0000, (is_w_s ? 1'b0 : imme[5]), imme[4:0], rs1, func3, rd, opcode};
          err  = is_w_s ? (imme > W'(SHAMTW_MAX)) : (imme > W'(SHAMT_MAX));
        end else begin
          word = {imme[11:0], rs1, func3, rd, opcode};
          err  = !fits(imme, IMM_I_BITS);
        end
      end
      FMT_S: begin
        word = {imme[11:5], rs2, rs1, func3, imme[4:0], opcode};
        err  = !fits(imme, IMM_S_BITS);
      end
      FMT_B: begin
        word = {imme[12], imme[10:5], rs2, rs1, func3, imme[4:1], imme[11], opcode};
        err  = !fits(imme, IMM_B_BITS) || imme[0];
      end
      FMT_U: begin
        word = {imme[31:12], rd, opcode};
        err  = !fits(imme, IMM_U_BITS) || (imme[11:0] != 12'd0);
      end
      FMT_J: begin
        word = {imme[20], imme[10:1], imme[11], imme[19:12], rd, opcode};
        err  = !fits(imme, IMM_J_BITS) || imme[0];
      end
      FMT_R: begin
        word = {1'b0, func7, 5'b00000, rs2, rs1, func3, rd, opcode};
        err  = 1'b0;
      end
      default: begin
        word = {1'b0, func7, 5'b00000, rs2, rs1, func3, rd, opcode};
        err  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encode.sv
// Two-stage RV64 instruction encoder with valid/ready handshake and immediate range flag.
// Define INSTR_ENC_ERRCNT_EN to implement the saturating err_cnt counter (tied to 0 otherwise).
module instr_encode
  import instr_encode_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [6:0]            opcode,
  input  logic [2:0]            func3,
  input  logic                  func7,
  input  logic [4:0]            Rs1,
  input  logic [4:0]            Rs2,
  input  logic [4:0]            Rd,
  input  logic [DATA_WIDTH-1:0] imme,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           instr,
  output logic                  imm_err,
  input  logic                  err_clr,
  output logic [15:0]           err_cnt
);

  logic [31:0] pack_word_s;
  logic        pack_err_s;
  logic        s1_valid_r;
  logic [31:0] s1_word_r;
  logic        s1_err_r;
  logic        s1_load_s;
  logic        s2_load_s;

  instr_encode_imm_pack #(.W(DATA_WIDTH)) u_imm_pack (
    .opcode (opcode),
    .func3  (func3),
    .func7  (func7),
    .rs1    (Rs1),
    .rs2    (Rs2),
    .rd     (Rd),
    .imme   (imme),
    .word   (pack_word_s),
    .err    (pack_err_s)
  );

  assign in_ready  = !s1_valid_r || !out_valid || out_ready;
  assign s1_load_s = in_valid && in_ready;
  assign s2_load_s = s1_valid_r && (!out_valid || out_ready);

  // Stage 1: captures the packed word and range result of an accepted bundle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_word_r  <= 32'd0;
      s1_err_r   <= 1'b0;
    end else if (s1_load_s) begin
      s1_valid_r <= 1'b1;
      s1_word_r  <= pack_word_s;
      s1_err_r   <= pack_err_s;
    end else if (s2_load_s) begin
      s1_valid_r <= 1'b0;
    end
  end

  // Stage 2: output register, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      instr     <= 32'd0;
      imm_err   <= 1'b0;
    end else if (s2_load_s) begin
      out_valid <= 1'b1;
      instr     <= s1_word_r;
      imm_err   <= s1_err_r;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef INSTR_ENC_ERRCNT_EN
  logic [15:0] err_cnt_r;

  // Saturating count of erroneous transfers; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_r <= 16'd0;
    end else if (err_clr) begin
      err_cnt_r <= 16'd0;
    end else if (out_valid && out_ready && imm_err && (err_cnt_r != 16'hFFFF)) begin
      err_cnt_r <= err_cnt_r + 16'd1;
    end
  end

  assign err_cnt = err_cnt_r;
`else
  logic err_clr_unused;
  assign err_clr_unused = err_clr;
  assign err_cnt        = 16'd0;
`endif

endmodule

// File: doc/instr_encode.md
# instr_encode

Pipelined RV64 instruction encoder: accepts decoded instruction fields (opcode, func3, func7 bit, register indices, 64-bit sign-extended immediate) over a valid/ready handshake and emits the packed 32-bit instruction word. It is the inverse of the core's decode stage and feeds instruction memory preload, self-test program generation, and decode-stage verification round-trips. A range checker flags immediates that cannot be represented in the selected format.

## Interface
- DATA_WIDTH, 64: immediate input width.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept this cycle.
- opcode  in  7  major opcode, using the shared define constants.
- func3  in  3  minor opcode.
- func7  in  1  bit destined for instr[30] (R-type, shift-immediate).
- Rs1, Rs2, Rd  in  5 each  register indices.
- imme  in  DATA_WIDTH  sign-extended immediate, byte offset for B/J, full value for U (low 12 bits zero).
- out_valid  out  1  instr valid.
- out_ready  in  1  consumer accepts.
- instr  out  32  encoded instruction.
- imm_err  out  1  immediate out of range for the format, qualified by out_valid.
- err_clr  in  1  synchronous clear of err_cnt.
- err_cnt  out  16  saturating count of imm_err transfers (see Configuration).

## Operation
- Format select from opcode. I: jalr, load, I_type, Iw_type. U: lui, auipc. J: jal. B: B_type. S: store. All others, including R and Rw, use R layout.
- Packing: opcode to [6:0], Rd to [11:7] (I/U/J/R), func3 to [14:12] (I/S/B/R), Rs1 to [19:15] (I/S/B/R), Rs2 to [24:20] (S/B/R).
- Immediate placement:
  - I: imm[11:0] to [31:20].
  - S: imm[11:5] to [31:25], imm[4:0] to [11:7].
  - B: {imm[12], imm[10:5]} to [31:25], {imm[4:1], imm[11]} to [11:7].
  - U: imm[31:12] to [31:12].
  - J: {imm[20], imm[10:1], imm[11], imm[19:12]} to [31:12].
  - R: [31:25] = {1'b0, func7, 5'b0}.
- Shift-immediate (I_type or Iw_type with func3 001/101): [31:26] = {1'b0, func7, 4'b0}, shamt to [25:20]. Iw_type forces [25] = 0.
- Range rules; violation sets imm_err, and the word is still emitted with the field truncated:
  - I, S: signed 12-bit.
  - B: signed 13-bit, bit0 = 0.
  - J: signed 21-bit, bit0 = 0.
  - U: signed 32-bit, imm[11:0] = 0.
  - Shift: I_type shamt 0..63, Iw_type 0..31.
  - R: never flags.
- Rs/Rd/func fields not used by the format are ignored and contribute 0 bits.

## Timing
- Two pipeline stages:
  - S1 registers the inputs plus format and range result.
  - S2 registers instr and imm_err.
- Latency is 2 cycles from in_valid&&in_ready to out_valid. Throughput is 1 per cycle.
- Stage advance: a stage loads when it is empty or its contents move on in the same cycle.
  - out side: a transfer occurs on out_valid&&out_ready.
  - in_ready = !s1_valid || (!s2_valid || out_ready); this path is combinational from out_ready.
- out_valid, instr and imm_err hold stable while out_valid&&!out_ready.
- Reset values:
  - in_ready = 1 (once reset deasserts).
  - out_valid = 0, instr = 0, imm_err = 0, err_cnt = 0.
  - Both stage valids clear. Reset mid-stream drops in-flight words with no partial output.
- err_cnt increments on an out_valid&&out_ready&&imm_err transfer and saturates at 0xFFFF.
- err_clr takes priority over a simultaneous increment; the result is 0.

## Configuration
- INSTR_ENC_ERRCNT_EN defined: err_cnt counter implemented as above.
- Undefined: counter logic is omitted, err_cnt is tied to 0 and err_clr is ignored. imm_err is unaffected.

## Structure
- Opcode constants come from the shared define file, with no local copies.
- Format enumeration (FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J) and range limits belong in a shared package so decode-side checkers reuse them.
- One sub-module, imm_pack: combinational format-to-field placement and range check. The top holds the handshake and pipeline registers.

## Test plan
- addi: opcode I_type, Rd=1, Rs1=0, func3=0, imme=5 -> instr 0x00500093, imm_err=0, after 2 cycles.
- lui and jal:
  - lui Rd=5, imme=0x12345000 -> 0x123452B7.
  - jal Rd=1, imme=2048 -> 0x001000EF.
- beq and srai:
  - beq Rs1=1, Rs2=2, imme=-4 -> 0xFE208EE3.
  - srai Rd=Rs1=3, func3=5, func7=1, imme=63 -> 0x43F1D193.
- Range error: addi Rd=1, imme=2048 -> 0x80000093 with imm_err=1, and err_cnt goes to 1 (with macro). B with imme=3 -> imm_err=1.
- Backpressure: stream 4 words with out_ready low for 3 cycles.
  - in_ready drops after 2 words are held.
  - Output is held stable, and no loss or duplication occurs on release.
- Reset and clear:
  - rst_n asserted with 2 words in flight -> out_valid=0 next edge, and nothing is emitted after release.
  - err_clr together with an error transfer -> err_cnt=0.
